mips_mem_arbiter: RTL



---
 rtl/mips_mem_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port unified memory between the MIPS
// instruction-fetch port (if_*) and the data load/store port (dm_*).
// Each access is sequenced IDLE -> ISSUE -> WAIT -> RESP. The memory has a
// fixed read latency. Data accesses win arbitration unless fetch has been
// passed over STARVE_LIMIT times in a row.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   if_req/if_addr    fetch request, held until if_ack
//   if_ack/if_rdata   one-cycle fetch completion pulse and fetched word
//   dm_req/dm_we/dm_addr/dm_wdata  data request, held until dm_ack
//   dm_ack/dm_rdata   one-cycle data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata  one-cycle memory access strobe and fields
//   mem_rdata         memory read data, valid MEM_LATENCY cycles after mem_en
//   busy              high whenever the sequencer is not idle
//
// Optional build macro MIPS_ARB_PERF_CNT_EN adds perf_if_grants,
// perf_dm_grants and perf_if_stall (32-bit wrapping counters).
module mips_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
`ifdef MIPS_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_if_grants,
  output logic [31:0]           perf_dm_grants,
  output logic [31:0]           perf_if_stall
`endif
);

  localparam logic [3:0] LatLast   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_dm_q, owner_dm_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  busy_q, busy_d;

  logic grant_valid;
  logic grant_dm;

  // Fetch wins a contested grant only once it has been starved to the limit.
  assign grant_valid = (state_q == StIdle) && (if_req || dm_req);
  assign grant_dm    = dm_req && !(if_req && (starve_cnt_q == StarveMax));

  always_comb begin
    state_d      = state_q;
    owner_dm_d   = owner_dm_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_dm_d = grant_dm;
          // Strobe is registered, so it is raised here to be high during ISSUE.
          mem_en_d   = 1'b1;
          mem_we_d   = grant_dm && dm_we;
          mem_addr_d = grant_dm ? dm_addr : if_addr;
          if (grant_dm) begin
            mem_wdata_d = dm_wdata;
          end
          if (grant_dm && if_req) begin
            starve_cnt_d = (starve_cnt_q == StarveMax) ? StarveMax : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = LatLast;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == 4'd0) begin
          // Ack is raised together with the capture so both appear in RESP.
          if (owner_dm_q) begin
            dm_rdata_d = mem_rdata;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_dm_q   <= 1'b0;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_dm_q   <= owner_dm_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

`ifdef MIPS_ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_dm_q, perf_dm_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_if_d    = perf_if_q;
    perf_dm_d    = perf_dm_q;
    perf_stall_d = perf_stall_q;
    if (grant_valid && grant_dm) begin
      perf_dm_d = perf_dm_q + 32'd1;
    end
    if (grant_valid && !grant_dm) begin
      perf_if_d = perf_if_q + 32'd1;
    end
    if (if_req && !if_ack_q) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q    <= '0;
      perf_dm_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_if_q    <= perf_if_d;
      perf_dm_q    <= perf_dm_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_if_grants = perf_if_q;
  assign perf_dm_grants = perf_dm_q;
  assign perf_if_stall  = perf_stall_q;
`endif

endmodule
